seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector and successor to the fixed 3-ones Moore detector.
- Pattern, length (1..MAX_LEN) and overlap mode are runtime-configurable through a load strobe.
- Input bits are qualified by a valid strobe.
- Moore-style registered match pulse and a saturating match counter.
- Sits in the small serial-stream utilities as a reusable framing/sync-word detector.

---
 rtl/seq_detector_param.sv | 99 +++++++++
 tb/tb_seq_detector_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with a registered one-cycle match pulse and a saturating hit counter.
// The pattern is compared right-aligned against a shift history; a fill count stops matches on a partially filled history.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(3'b111),
  parameter int                 DEF_LEN     = 3,
  parameter bit                 DEF_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cfg_len
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] nh;
  logic [LEN_W-1:0]   nf;
  logic               match;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    nh    = {hist_q[MAX_LEN-2:0], in};
    nf    = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    // A load cycle discards the incoming bit, so it can never complete a match.
    match = in_valid && !cfg_load && (len_q != '0) && (nf >= len_q) &&
            (((nh ^ pat_q) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    out_d  = match;

    if (cfg_load) begin
      pat_d  = pattern;
      len_d  = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
      ovl_d  = overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = nh;
      fill_d = (match && !ovl_q) ? '0 : nf;
    end

    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign cfg_len     = len_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a vector table with expected match pulses feeds a scoreboard queue;
// a second instance with a 2-bit counter exposes saturation. Reset-mid-pattern is a hand-written sequence.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in, cfg_load, count_clr, overlap;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               out, out2;
  logic [7:0]         match_count;
  logic [1:0]         match_count2;
  logic [LEN_W-1:0]   cfg_len, cfg_len2;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .count_clr(count_clr),
    .out(out), .match_count(match_count), .cfg_len(cfg_len)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .count_clr(count_clr),
    .out(out2), .match_count(match_count2), .cfg_len(cfg_len2)
  );

  typedef struct {
    logic               v;
    logic               b;
    logic               ld;
    logic               clr;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ov;
    logic               e;
  } vec_t;

  typedef struct {
    logic e_out;
    int   cnt;
    int   cnt2;
    int   len;
    int   id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  int   m_cnt2 = 0;
  int   m_len  = 3;
  int   vid    = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic bit_(input logic b, input logic e);
    tbl.push_back('{1'b1, b, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, e});
  endtask

  task automatic gap_();
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0});
  endtask

  task automatic load_(input logic [7:0] p, input logic [3:0] l, input logic o, input logic v, input logic b);
    tbl.push_back('{v, b, 1'b1, 1'b0, p, l, o, 1'b0});
  endtask

  task automatic clr_(input logic v, input logic b, input logic e);
    tbl.push_back('{v, b, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, e});
  endtask

  task automatic check_head();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", vid, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("out", x.id, 32'(out), 32'(x.e_out));
      chk("out_cnt2_inst", x.id, 32'(out2), 32'(x.e_out));
      chk("match_count", x.id, 32'(match_count), x.cnt);
      chk("match_count_sat2", x.id, 32'(match_count2), x.cnt2);
      chk("cfg_len", x.id, 32'(cfg_len), x.len);
    end
  endtask

  task automatic apply(input vec_t t);
    in_valid  = t.v;
    in        = t.b;
    cfg_load  = t.ld;
    count_clr = t.clr;
    pattern   = t.pat;
    pat_len   = t.len;
    overlap   = t.ov;
    if (t.ld) m_len = (t.len > 4'd8) ? 8 : int'(t.len);
    if (t.clr) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (t.e) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    sb.push_back('{t.e, m_cnt, m_cnt2, m_len, vid});
    @(posedge clk);
    #1;
    check_head();
    vid++;
  endtask

  initial begin
    vec_t rv;
    reset = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    overlap = 1'b0; pattern = '0; pat_len = '0;

    // Defaults, non-overlap: 4th consecutive 1 starts the next pattern.
    for (int i = 0; i < 7; i++) bit_(1'b1, (i == 2) || (i == 5));
    // 1011 overlapping, then non-overlapping.
    load_(8'b1011, 4'd4, 1'b1, 1'b0, 1'b0);
    bit_(1,0); bit_(0,0); bit_(1,0); bit_(1,1); bit_(0,0); bit_(1,0); bit_(1,1);
    load_(8'b1011, 4'd4, 1'b0, 1'b0, 1'b0);
    bit_(1,0); bit_(0,0); bit_(1,0); bit_(1,1); bit_(0,0); bit_(1,0); bit_(1,0);
    // 111 overlapping: four back-to-back pulses.
    load_(8'b111, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) bit_(1'b1, i >= 2);
    // Valid bits separated by idle gaps.
    load_(8'b111, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_(1'b1, i == 2); gap_(); gap_();
    end
    // Counter saturation on the 2-bit instance, then clear coincident with a match.
    clr_(1'b0, 1'b0, 1'b0);
    load_(8'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_(1'b1, 1'b1);
    clr_(1'b1, 1'b1, 1'b1);
    bit_(1'b0, 1'b0);
    // Length zero disables detection even though pattern 0 would match.
    load_(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_(1'b0, 1'b0);
    // Over-long length clamps to 8: full-width pattern A5.
    load_(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0);
    bit_(1,0); bit_(0,0); bit_(1,0); bit_(0,0); bit_(0,0); bit_(1,0); bit_(0,0); bit_(1,1);
    // Bit arriving with the load strobe is discarded.
    load_(8'b111, 4'd3, 1'b0, 1'b1, 1'b1);
    bit_(1,0); bit_(1,0); bit_(1,1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", -1, 32'(out), 32'd0);
    chk("reset_count", -1, 32'(match_count), 32'd0);
    chk("reset_cfg_len", -1, 32'(cfg_len), 32'd3);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset after two of three pattern bits: the partial history must be lost.
    rv = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
    apply(rv);
    apply(rv);
    reset = 1'b1;
    #3;
    chk("midreset_out", vid, 32'(out), 32'd0);
    chk("midreset_count", vid, 32'(match_count), 32'd0);
    chk("midreset_cfg_len", vid, 32'(cfg_len), 32'd3);
    m_cnt = 0; m_cnt2 = 0; m_len = 3;
    @(negedge clk);
    reset = 1'b0;
    apply(rv);
    apply(rv);
    rv.e = 1'b1;
    apply(rv);

    chk("scoreboard_empty", vid, 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
